// File: rtl/mux_n2m_lane_serializer_pkg.sv
// Shared definitions for the N:M lane serializer: FSM state encoding and the
// width helper for the slot (phase) index.
package mux_n2m_lane_serializer_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

   // Width of the slot index; a 1-bit field even for RATIO=2 or below.
   function automatic int phase_width(input int ratio);
      return (ratio > 2) ? $clog2(ratio) : 1;
   endfunction

endpackage

// File: rtl/mux_n2m_lane_serializer_slot_sel.sv
// Registered RATIO:1 selector for one output lane. Picks the buffered input
// lane addressed by phase and zeroes data/valid when that lane is invalid,
// when the serializer is not emitting, or under reset.
module mux_n2m_lane_serializer_slot_sel #(
   parameter int DATA_W  = 8,
   parameter int RATIO   = 2,
   parameter int PHASE_W = 1
) (
   input  logic                      clk_2f,
   input  logic                      reset,
   input  logic                      en,
   input  logic [PHASE_W-1:0]        phase,
   input  logic [RATIO*DATA_W-1:0]   slice_data,
   input  logic [RATIO-1:0]          slice_valid,
   output logic [DATA_W-1:0]         data,
   output logic                      valid
);

   // Register the selected slot; invalid lanes never forward their data.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_2f) begin
      if (reset || !en) begin
         data  <= '0;
         valid <= 1'b0;
      end else if (slice_valid[phase]) begin
         data  <= slice_data[int'(phase)*DATA_W +: DATA_W];
         valid <= 1'b1;
      end else begin
         data  <= '0;
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/mux_n2m_lane_serializer.sv
// N:M lane serializer. Captures NUM_IN byte lanes into a holding buffer and
// time-multiplexes them onto NUM_IN/RATIO output lanes, one slot per clock.
// Output lane j in slot r carries input lane j*RATIO+r. Optionally skips
// slots that are invalid on every output lane.
module mux_n2m_lane_serializer
   import mux_n2m_lane_serializer_pkg::*;
#(
   parameter  int DATA_W       = 8,
   parameter  int NUM_IN       = 4,
   parameter  int RATIO        = 2,
   parameter  int SKIP_INVALID = 0,
   localparam int NUM_OUT      = NUM_IN / RATIO,
   localparam int PHASE_W      = phase_width(RATIO)
) (
   input  logic                        clk_2f,
   input  logic                        reset,
   input  logic [NUM_IN*DATA_W-1:0]    in_data,
   input  logic [NUM_IN-1:0]           in_valid,
   input  logic                        in_load,
   output logic                        in_ready,
   output logic [NUM_OUT*DATA_W-1:0]   out_data,
   output logic [NUM_OUT-1:0]          out_valid,
   output logic [PHASE_W-1:0]          out_phase
);

   typedef logic [PHASE_W-1:0] phase_t;

   if ((NUM_IN % RATIO) != 0 || RATIO < 2) begin : g_bad_params
      $error("mux_n2m_lane_serializer: NUM_IN must be a multiple of RATIO and RATIO >= 2");
   end

   state_t                     state;
   phase_t                     phase;
   logic [NUM_IN*DATA_W-1:0]   buf_data;
   logic [NUM_IN-1:0]          buf_valid;
   logic [RATIO-1:0]           live_in;
   logic [RATIO-1:0]           live_buf;
   phase_t                     first_in;
   phase_t                     next_live;
   logic                       any_in;
   logic                       has_next;
   logic                       accept;
   logic                       emit;

   // Live-slot search: lowest live slot of the incoming group and the next
   // live slot above the current phase in the buffered group.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      live_in   = '0;
      live_buf  = '0;
      first_in  = '0;
      next_live = '0;
      any_in    = 1'b0;
      has_next  = 1'b0;
      for (int r = 0; r < RATIO; r++) begin
         for (int j = 0; j < NUM_OUT; j++) begin
            live_in[r]  = live_in[r]  | in_valid[j*RATIO + r];
            live_buf[r] = live_buf[r] | buf_valid[j*RATIO + r];
         end
      end
      if (SKIP_INVALID == 0) begin
         live_in  = '1;
         live_buf = '1;
      end
      for (int r = RATIO - 1; r >= 0; r--) begin
         if (live_in[r]) begin
            first_in = phase_t'(r);
            any_in   = 1'b1;
         end
         if (live_buf[r] && (r > int'(phase))) begin
            next_live = phase_t'(r);
            has_next  = 1'b1;
         end
      end
   end

   assign emit     = (state == ST_EMIT);
   assign in_ready = !reset && (!emit || !has_next);
   assign accept   = in_load && in_ready;

   // FSM, phase counter, holding buffer and registered slot index.
   // NOTE: the holding buffer is reset too, so a group cut off by reset cannot leak out later.
   always_ff @(posedge clk_2f) begin
      if (reset) begin
         state     <= ST_IDLE;
         phase     <= '0;
         buf_data  <= '0;
         buf_valid <= '0;
         out_phase <= '0;
      end else begin
         out_phase <= emit ? phase : '0;
         case (state)
            ST_IDLE: begin
               if (accept && any_in) begin
                  buf_data  <= in_data;
                  buf_valid <= in_valid;
                  phase     <= first_in;
                  state     <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               if (has_next) begin
                  phase <= next_live;
               end else if (accept && any_in) begin
                  buf_data  <= in_data;
                  buf_valid <= in_valid;
                  phase     <= first_in;
               end else begin
                  phase <= '0;
                  state <= ST_IDLE;
               end
            end
            default: begin
               phase <= '0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   for (genvar j = 0; j < NUM_OUT; j++) begin : g_lane
      mux_n2m_lane_serializer_slot_sel #(
         .DATA_W  (DATA_W),
         .RATIO   (RATIO),
         .PHASE_W (PHASE_W)
      ) u_slot_sel (
         .clk_2f      (clk_2f),
         .reset       (reset),
         .en          (emit),
         .phase       (phase),
         .slice_data  (buf_data[j*RATIO*DATA_W +: RATIO*DATA_W]),
         .slice_valid (buf_valid[j*RATIO +: RATIO]),
         .data        (out_data[j*DATA_W +: DATA_W]),
         .valid       (out_valid[j])
      );
   end

endmodule

// File: tb/tb_mux_n2m_lane_serializer.sv
// Bench for the N:M lane serializer. Two instances: the default configuration
// (4 lanes, ratio 2) and a skip-mode configuration (8 lanes, ratio 4).
// A queue-of-slots model predicts every output and in_ready each cycle;
// directed sequences pin the model with literal values.
module tb_mux_n2m_lane_serializer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic [31:0] a_data  = '0;
   logic [3:0]  a_valid = '0;
   logic        a_load  = 1'b0;
   logic        a_ready;
   logic [15:0] a_odata;
   logic [1:0]  a_ovalid;
   logic [0:0]  a_phase;

   logic [63:0] b_data  = '0;
   logic [7:0]  b_valid = '0;
   logic        b_load  = 1'b0;
   logic        b_ready;
   logic [15:0] b_odata;
   logic [1:0]  b_ovalid;
   logic [1:0]  b_phase;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mux_n2m_lane_serializer #(.DATA_W(8), .NUM_IN(4), .RATIO(2), .SKIP_INVALID(0)) u_dut_a (
      .clk_2f(clk), .reset(rst), .in_data(a_data), .in_valid(a_valid), .in_load(a_load),
      .in_ready(a_ready), .out_data(a_odata), .out_valid(a_ovalid), .out_phase(a_phase));

   mux_n2m_lane_serializer #(.DATA_W(8), .NUM_IN(8), .RATIO(4), .SKIP_INVALID(1)) u_dut_b (
      .clk_2f(clk), .reset(rst), .in_data(b_data), .in_valid(b_valid), .in_load(b_load),
      .in_ready(b_ready), .out_data(b_odata), .out_valid(b_ovalid), .out_phase(b_phase));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [15:0] d;
      logic [1:0]  v;
      int          ph;
   } slot_t;

   slot_t qa[$];
   slot_t qb[$];
   slot_t exp_a = '{d: '0, v: '0, ph: 0};
   slot_t exp_b = '{d: '0, v: '0, ph: 0};
   slot_t grp[4];
   int    grp_n;

   // Expand one loaded group into the list of slots it will put on the outputs.
   function automatic void make_group(input int num_in, input int ratio, input int skip,
                                      input logic [63:0] d, input logic [7:0] v);
      grp_n = 0;
      for (int r = 0; r < ratio; r++) begin
         slot_t t;
         bit    live;
         t.d  = '0;
         t.v  = '0;
         t.ph = r;
         live = 1'b0;
         for (int j = 0; j < num_in / ratio; j++) begin
            int idx;
            idx = j * ratio + r;
            if (v[idx]) begin
               t.v[j]          = 1'b1;
               t.d[j*8 +: 8]   = d[idx*8 +: 8];
               live            = 1'b1;
            end
         end
         if (skip == 0 || live) begin
            grp[grp_n] = t;
            grp_n++;
         end
      end
   endfunction

   // Compare the outputs of the last edge, then advance the model with the
   // inputs the next edge will sample (inputs only change just after posedge).
   always @(negedge clk) begin
      bit rdy_a;
      bit rdy_b;
      check("a_out_data",  {48'b0, a_odata},  {48'b0, exp_a.d});
      check("a_out_valid", {62'b0, a_ovalid}, {62'b0, exp_a.v});
      check("a_out_phase", {63'b0, a_phase},  64'(exp_a.ph));
      check("b_out_data",  {48'b0, b_odata},  {48'b0, exp_b.d});
      check("b_out_valid", {62'b0, b_ovalid}, {62'b0, exp_b.v});
      check("b_out_phase", {62'b0, b_phase},  64'(exp_b.ph));
      rdy_a = !rst && (qa.size() <= 1);
      rdy_b = !rst && (qb.size() <= 1);
      check("a_in_ready", {63'b0, a_ready}, {63'b0, rdy_a});
      check("b_in_ready", {63'b0, b_ready}, {63'b0, rdy_b});
      if (rst) begin
         qa.delete();
         qb.delete();
         exp_a = '{d: '0, v: '0, ph: 0};
         exp_b = '{d: '0, v: '0, ph: 0};
      end else begin
         exp_a = (qa.size() > 0) ? qa.pop_front() : '{d: '0, v: '0, ph: 0};
         exp_b = (qb.size() > 0) ? qb.pop_front() : '{d: '0, v: '0, ph: 0};
         if (a_load && rdy_a) begin
            make_group(4, 2, 0, {32'b0, a_data}, {4'b0, a_valid});
            for (int i = 0; i < grp_n; i++) qa.push_back(grp[i]);
         end
         if (b_load && rdy_b) begin
            make_group(8, 4, 1, b_data, b_valid);
            for (int i = 0; i < grp_n; i++) qb.push_back(grp[i]);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   initial begin
      // Reset held for three edges.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_a_data",  {48'b0, a_odata},  64'h0);
         check("rst_a_valid", {62'b0, a_ovalid}, 64'h0);
         check("rst_a_ready", {63'b0, a_ready},  64'h0);
         check("rst_b_ready", {63'b0, b_ready},  64'h0);
      end
      cyc();
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_a_ready", {63'b0, a_ready}, 64'h1);
      check("post_rst_b_ready", {63'b0, b_ready}, 64'h1);

      // Single group.
      cyc();
      a_data = 32'hB1B0_A1A0; a_valid = 4'hF; a_load = 1'b1;
      cyc();
      a_load = 1'b0;
      cyc();
      @(negedge clk);
      check("single_s0_data",  {48'b0, a_odata},  64'hB0A0);
      check("single_s0_valid", {62'b0, a_ovalid}, 64'h3);
      check("single_s0_phase", {63'b0, a_phase},  64'h0);
      cyc();
      @(negedge clk);
      check("single_s1_data",  {48'b0, a_odata},  64'hB1A1);
      check("single_s1_phase", {63'b0, a_phase},  64'h1);
      cyc();
      @(negedge clk);
      check("single_idle_valid", {62'b0, a_ovalid}, 64'h0);
      check("single_idle_data",  {48'b0, a_odata},  64'h0);

      // Partial valid.
      cyc();
      a_data = 32'h4433_2211; a_valid = 4'b0110; a_load = 1'b1;
      cyc();
      a_load = 1'b0;
      cyc();
      @(negedge clk);
      check("partial_s0_data",  {48'b0, a_odata},  64'h3300);
      check("partial_s0_valid", {62'b0, a_ovalid}, 64'h2);
      cyc();
      @(negedge clk);
      check("partial_s1_data",  {48'b0, a_odata},  64'h0022);
      check("partial_s1_valid", {62'b0, a_ovalid}, 64'h1);

      // Back-to-back: three groups, six slots with no gap.
      cyc();
      a_data = 32'hDEAD_BEEF; a_valid = 4'hF; a_load = 1'b1;
      cyc();
      for (int i = 0; i < 6; i++) begin
         cyc();
         if (i == 3) a_load = 1'b0;
         @(negedge clk);
         check("b2b_phase", {63'b0, a_phase},  64'(i % 2));
         check("b2b_valid", {62'b0, a_ovalid}, 64'h3);
      end

      // Skip mode: only slots 0 and 3 are live.
      cyc();
      b_data = 64'h8877_6655_4433_2211; b_valid = 8'b1000_0001; b_load = 1'b1;
      cyc();
      b_load = 1'b0;
      cyc();
      @(negedge clk);
      check("skip_s0_phase", {62'b0, b_phase},  64'h0);
      check("skip_s0_data",  {48'b0, b_odata},  64'h0011);
      check("skip_s0_valid", {62'b0, b_ovalid}, 64'h1);
      cyc();
      @(negedge clk);
      check("skip_s3_phase", {62'b0, b_phase},  64'h3);
      check("skip_s3_data",  {48'b0, b_odata},  64'h8800);
      check("skip_s3_ready", {63'b0, b_ready},  64'h1);

      // Skip mode: an all-invalid group is accepted and dropped.
      cyc();
      b_valid = 8'h00; b_load = 1'b1;
      cyc();
      b_load = 1'b0;
      cyc();
      @(negedge clk);
      check("skip_empty_valid", {62'b0, b_ovalid}, 64'h0);
      check("skip_empty_ready", {63'b0, b_ready},  64'h1);

      // Reset during the slot-0 output cycle.
      cyc();
      a_data = 32'h5A5A_C3C3; a_valid = 4'hF; a_load = 1'b1;
      cyc();
      a_load = 1'b0;
      cyc();
      rst = 1'b1;
      @(negedge clk);
      check("midrst_s0_data", {48'b0, a_odata}, 64'h5AC3);
      cyc();
      rst = 1'b0;
      @(negedge clk);
      check("midrst_data",  {48'b0, a_odata},  64'h0);
      check("midrst_valid", {62'b0, a_ovalid}, 64'h0);
      check("midrst_ready", {63'b0, a_ready},  64'h1);
      cyc();
      @(negedge clk);
      check("midrst_no_s1", {62'b0, a_ovalid}, 64'h0);

      // Randomised traffic on both instances, checked by the model.
      for (int i = 0; i < 600; i++) begin
         cyc();
         rst     = ($urandom_range(0, 59) == 0);
         a_load  = ($urandom_range(0, 3) != 0);
         a_data  = $urandom;
         a_valid = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
         b_load  = ($urandom_range(0, 3) != 0);
         b_data  = {$urandom, $urandom};
         b_valid = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      end
      cyc();
      rst    = 1'b0;
      a_load = 1'b0;
      b_load = 1'b0;
      repeat (8) cyc();
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
